// File: rtl/io_bus_responder.sv
// rtl/io_bus_responder.sv - memory-mapped LED/HEX/switch/timer responder with one-cycle read latency
module io_bus_responder #(
  parameter int PRESCALE = 50000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  input  logic [15:0] RAMDATA,
  input  logic [15:0] SW,
  output logic [15:0] DIN,
  output logic        RAMen,
  output logic [15:0] LEDS,
  output logic [15:0] HEXVAL,
  output logic        TIMER_IRQ
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [3:0]  SEL_UNMAPPED = 4'hF;

  typedef enum logic {IDLE, RUN} tstate_t;

  logic [3:0]  region;
  logic        wr_led, wr_hex, wr_load, wr_stat;
  logic [15:0] leds_r, hex_r;
  logic [15:0] sw_s1, sw_s2;
  logic [15:0] count, presc;
  logic        done;
  tstate_t     state;
  logic [15:0] read_val, rd_data;
  logic [3:0]  sel_region;
  logic        unused_addr;

  assign region  = ADDR[15:12];
  assign wr_led  = W && (region == 4'h1);
  assign wr_hex  = W && (region == 4'h3);
  assign wr_load = W && (region == 4'h4) && !ADDR[0];
  assign wr_stat = W && (region == 4'h4) && ADDR[0];
  assign RAMen   = W && (region == 4'h0);

  assign unused_addr = &{1'b0, ADDR[11:1]};

  assign LEDS      = leds_r;
  assign HEXVAL    = hex_r;
  assign TIMER_IRQ = done;

  // Peripheral read value from the pre-edge state; the RAM supplies its own registered data.
  always_comb begin
    read_val = 16'h0000;
    case (region)
      4'h1:    read_val = leds_r;
      4'h2:    read_val = sw_s2;
      4'h3:    read_val = hex_r;
      4'h4:    read_val = ADDR[0] ? {14'b0, (state == RUN), done} : count;
      default: read_val = 16'h0000;
    endcase
  end

  // Return-data mux steered by the region latched on the previous edge.
  always_comb begin
    DIN = 16'h0000;
    case (sel_region)
      4'h0:                   DIN = RAMDATA;
      4'h1, 4'h2, 4'h3, 4'h4: DIN = rd_data;
      default:                DIN = 16'h0000;
    endcase
  end

  // Read pipeline stage: latch select and sampled data so peripherals line up with the RAM latency.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_region <= SEL_UNMAPPED;
      rd_data    <= 16'h0000;
    end else begin
      sel_region <= region;
      rd_data    <= read_val;
    end
  end

  // Output registers and the two-flop switch synchronizer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      leds_r <= 16'h0000;
      hex_r  <= 16'h0000;
      sw_s1  <= 16'h0000;
      sw_s2  <= 16'h0000;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      if (wr_led) leds_r <= DOUT;
      if (wr_hex) hex_r  <= DOUT;
    end
  end

  // Countdown timer; expiry is written last so it beats a same-edge STATUS clear, while LOAD beats both.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      count <= 16'h0000;
      presc <= 16'h0000;
      done  <= 1'b0;
    end else if (wr_load) begin
      count <= DOUT;
      presc <= 16'h0000;
      if (DOUT != 16'h0000) begin
        state <= RUN;
        done  <= 1'b0;
      end else begin
        state <= IDLE;
        done  <= 1'b1;
      end
    end else begin
      if (wr_stat && DOUT[0]) done <= 1'b0;
      if (state == RUN) begin
        if (presc == PRE_MAX) begin
          presc <= 16'h0000;
          count <= count - 16'd1;
          if (count == 16'd1) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end else begin
          presc <= presc + 16'd1;
        end
      end
    end
  end

endmodule
